// File: rtl/alu_resp_checker.sv
// rtl/alu_resp_checker.sv - response checker for exhaustive ALU slice operand sweeps
//
// Purpose: consumes {a,b,c} triples from an ALU slice under test and recomputes
// the expected result for the latched op. It counts matches and mismatches,
// checks that {a,b} arrives in incrementing order, and raises done/pass once all
// 2^(2*SIZE) operand pairs have been seen.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   start               pulse: latch op, clear results, begin sweep (IDLE/DONE only)
//   op[1:0]             00 AND, 01 OR, 10 XOR, 11 ADD mod 2^SIZE
//   in_valid/in_ready   beat handshake for the a/b/c triple
//   a, b, c             operands and slice result under test
//   busy, done, pass    sweep status and verdict
//   pass_cnt, fail_cnt  matching / mismatching triple counts
//   seq_err             sticky out-of-order flag
//   ff_a, ff_b, ff_c    first failing triple (only with CHK_FIRST_FAIL_EN)
//
// Optional feature macro: CHK_FIRST_FAIL_EN
module alu_resp_checker #(
  parameter int SIZE = 4,
  parameter int CW   = 2*SIZE+1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic [SIZE-1:0] c,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [CW-1:0]   pass_cnt,
  output logic [CW-1:0]   fail_cnt,
`ifdef CHK_FIRST_FAIL_EN
  output logic [SIZE-1:0] ff_a,
  output logic [SIZE-1:0] ff_b,
  output logic [SIZE-1:0] ff_c,
`endif
  output logic            seq_err
);

  localparam int IW = 2*SIZE;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            s1_vld_q, s1_vld_d;
  logic            s1_match_q, s1_match_d;
  logic [CW-1:0]   pass_cnt_q, pass_cnt_d;
  logic [CW-1:0]   fail_cnt_q, fail_cnt_d;
  logic            seq_err_q, seq_err_d;
`ifdef CHK_FIRST_FAIL_EN
  logic [SIZE-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d, s1_c_q, s1_c_d;
  logic [SIZE-1:0] ff_a_q, ff_a_d, ff_b_q, ff_b_d, ff_c_q, ff_c_d;
`endif

  logic            beat;
  logic [SIZE-1:0] expected;

  assign beat = in_valid && (state_q == S_RUN);

  // ADD keeps only SIZE bits: the carry out of the slice is not part of c.
  always_comb begin
    expected = '0;
    case (op_q)
      2'b00:   expected = a & b;
      2'b01:   expected = a | b;
      2'b10:   expected = a ^ b;
      default: expected = a + b;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    idx_d      = idx_q;
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    seq_err_d  = seq_err_q;
    s1_vld_d   = beat;
    s1_match_d = (c == expected);
`ifdef CHK_FIRST_FAIL_EN
    s1_a_d = a;
    s1_b_d = b;
    s1_c_d = c;
    ff_a_d = ff_a_q;
    ff_b_d = ff_b_q;
    ff_c_d = ff_c_q;
`endif

    // Stage 2: retire the beat registered on the previous edge.
    if (s1_vld_q) begin
      if (s1_match_q) begin
        pass_cnt_d = pass_cnt_q + CW'(1);
      end else begin
        fail_cnt_d = fail_cnt_q + CW'(1);
`ifdef CHK_FIRST_FAIL_EN
        if (fail_cnt_q == '0) begin
          ff_a_d = s1_a_q;
          ff_b_d = s1_b_q;
          ff_c_d = s1_c_q;
        end
`endif
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        // A new sweep overrides any stage-2 update on the same edge.
        if (start) begin
          state_d    = S_RUN;
          op_d       = op;
          idx_d      = '0;
          pass_cnt_d = '0;
          fail_cnt_d = '0;
          seq_err_d  = 1'b0;
          s1_vld_d   = 1'b0;
`ifdef CHK_FIRST_FAIL_EN
          ff_a_d = '0;
          ff_b_d = '0;
          ff_c_d = '0;
`endif
        end
      end
      S_RUN: begin
        if (beat) begin
          if ({a, b} != idx_q) seq_err_d = 1'b1;
          idx_d = idx_q + IW'(1);
          if (idx_q == {IW{1'b1}}) state_d = S_DRAIN;
        end
      end
      default: state_d = S_DONE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= 2'b00;
      idx_q      <= '0;
      s1_vld_q   <= 1'b0;
      s1_match_q <= 1'b0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      seq_err_q  <= 1'b0;
`ifdef CHK_FIRST_FAIL_EN
      s1_a_q <= '0;
      s1_b_q <= '0;
      s1_c_q <= '0;
      ff_a_q <= '0;
      ff_b_q <= '0;
      ff_c_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      idx_q      <= idx_d;
      s1_vld_q   <= s1_vld_d;
      s1_match_q <= s1_match_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      seq_err_q  <= seq_err_d;
`ifdef CHK_FIRST_FAIL_EN
      s1_a_q <= s1_a_d;
      s1_b_q <= s1_b_d;
      s1_c_q <= s1_c_d;
      ff_a_q <= ff_a_d;
      ff_b_q <= ff_b_d;
      ff_c_q <= ff_c_d;
`endif
    end
  end

  assign in_ready = (state_q == S_RUN);
  assign busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done     = (state_q == S_DONE);
  assign pass     = done && (fail_cnt_q == '0) && !seq_err_q;
  assign pass_cnt = pass_cnt_q;
  assign fail_cnt = fail_cnt_q;
  assign seq_err  = seq_err_q;
`ifdef CHK_FIRST_FAIL_EN
  assign ff_a = ff_a_q;
  assign ff_b = ff_b_q;
  assign ff_c = ff_c_q;
`endif

endmodule
